counter6bit_seq_ctrl: RTL and testbench

//  Sequencer for the 6-bit enable/clear counter. Latches a terminal value and

---
 rtl/counter6bit_seq_ctrl_pkg.sv | 15 +
 rtl/counter6bit_seq_ctrl_prescale_tick.sv | 36 +++
 rtl/counter6bit_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_counter6bit_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter6bit_seq_ctrl_pkg.sv
// Shared definitions for the counter6bit sequencer: state encoding and the
// default widths used by counter6bit users.
package counter6bit_seq_ctrl_pkg;

    localparam int CNT_W_DEF = 6;
    localparam int PRE_W_DEF = 4;
    localparam int PER_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/counter6bit_seq_ctrl_prescale_tick.sv
// Prescale divider for the sequencer: a phase counter running 0..div.
// tick looks one cycle ahead, so the parent can register its outputs for a wrap cycle.
module prescale_tick
    import counter6bit_seq_ctrl_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             restart,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] phase;
    logic [PRE_W-1:0] phase_n;

    // restart puts the coming cycle at phase 0; tick flags that the coming cycle is a wrap
    always_comb begin
        if (restart || (phase == div)) begin
            phase_n = '0;
        end else begin
            phase_n = phase + PRE_W'(1);
        end
        tick = (phase_n == div);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            phase <= '0;
        end else begin
            phase <= phase_n;
        end
    end

endmodule

// File: rtl/counter6bit_seq_ctrl.sv
// Sequencer for one counter6bit: latches terminal/prescale/mode at start, drives
// the counter's clear and enable, and reports completion and the period tally.
module counter6bit_seq_ctrl
    import counter6bit_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF,
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] term_val,
    input  logic [PRE_W-1:0] prescale,
    input  logic [CNT_W-1:0] count_in,
    output logic             cnt_clear,
    output logic             cnt_enable,
    output logic             busy,
    output logic             done,
    output logic [PER_W-1:0] periods
);

    state_t           state, state_n;
    logic [CNT_W-1:0] term_q, term_n;
    logic [PRE_W-1:0] pre_q, pre_n;
    logic             per_q, per_n;
    logic             tick_q;
    logic             tick_nx;
    logic [PER_W-1:0] periods_n;
    logic             clear_n, en_n, busy_n, done_n;
    logic [CNT_W-1:0] pred_cnt;

    prescale_tick #(.PRE_W(PRE_W)) u_tick (
        .clock   (clock),
        .clear   (clear),
        .restart (state == S_CLR),
        .div     (pre_q),
        .tick    (tick_nx)
    );

    // Value the counter will show next cycle, given what we are driving into it now.
    // While cnt_clear is high this is 0, which also covers the cycles before the first tick.
    assign pred_cnt = cnt_clear ? '0 : (count_in + CNT_W'(cnt_enable));

    always_comb begin
        state_n   = state;
        term_n    = term_q;
        pre_n     = pre_q;
        per_n     = per_q;
        periods_n = periods;
        clear_n   = 1'b0;
        en_n      = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    term_n    = term_val;
                    pre_n     = prescale;
                    per_n     = periodic;
                    periods_n = '0;
                    state_n   = S_CLR;
                    clear_n   = 1'b1;
                    busy_n    = 1'b1;
                end
            end
            S_CLR: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_RUN;
                    busy_n  = 1'b1;
                    en_n    = tick_nx && (pred_cnt != term_q);
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else if (done) begin
                    // done cycle closes the run; periodic mode goes straight to a new clear
                    if (per_q) begin
                        state_n = S_CLR;
                        clear_n = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    busy_n = 1'b1;
                    if (tick_q && (count_in == term_q)) begin
                        done_n = 1'b1;
                        if (per_q) begin
                            periods_n = periods + PER_W'(1);
                        end
                    end else begin
                        // enable is withheld once the next count would already be terminal
                        en_n = tick_nx && (pred_cnt != term_q);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= S_IDLE;
            term_q     <= '0;
            pre_q      <= '0;
            per_q      <= 1'b0;
            tick_q     <= 1'b0;
            periods    <= '0;
            cnt_clear  <= 1'b1;
            cnt_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            term_q     <= term_n;
            pre_q      <= pre_n;
            per_q      <= per_n;
            tick_q     <= tick_nx;
            periods    <= periods_n;
            cnt_clear  <= clear_n;
            cnt_enable <= en_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_counter6bit_seq_ctrl.sv
// Bench for counter6bit_seq_ctrl driving a behavioural counter6bit; done pulses
// are scored against a queue of expected (cycle, count, periods) records.
module tb_counter6bit_seq_ctrl;
    import counter6bit_seq_ctrl_pkg::*;

    localparam int CNT_W = 6;
    localparam int PRE_W = 4;
    localparam int PER_W = 8;

    logic             clock = 1'b0;
    logic             clear = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             periodic = 1'b0;
    logic [CNT_W-1:0] term_val = '0;
    logic [PRE_W-1:0] prescale = '0;
    logic [CNT_W-1:0] count_in;
    logic             cnt_clear, cnt_enable, busy, done;
    logic [PER_W-1:0] periods;
    logic [CNT_W-1:0] cnt_q = 6'h2a;

    typedef struct {
        logic             per;
        logic [CNT_W-1:0] term;
        logic [PRE_W-1:0] pre;
        int               nper;
    } vec_t;

    typedef struct {
        int               cyc;
        logic [CNT_W-1:0] cnt;
        logic [PER_W-1:0] per;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   en_cnt = 0;

    counter6bit_seq_ctrl #(.CNT_W(CNT_W), .PRE_W(PRE_W), .PER_W(PER_W)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .periodic   (periodic),
        .term_val   (term_val),
        .prescale   (prescale),
        .count_in   (count_in),
        .cnt_clear  (cnt_clear),
        .cnt_enable (cnt_enable),
        .busy       (busy),
        .done       (done),
        .periods    (periods)
    );

    // counter6bit: clear has priority over enable
    always @(posedge clock) begin
        if (cnt_clear) cnt_q <= '0;
        else if (cnt_enable) cnt_q <= cnt_q + 6'd1;
    end
    assign count_in = cnt_q;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // scoreboard side: every done pulse must match the oldest expected record
    always @(negedge clock) begin
        exp_t e;
        if (cnt_enable) en_cnt++;
        if (done) begin
            chk("done_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_count", int'(count_in), int'(e.cnt));
                chk("done_periods", int'(periods), int'(e.per));
            end
        end
    end

    // One run: start at cycle c, k-th done expected at c + k*L with
    // L = 2 + (term+1)*(prescale+1); afterwards stop and check the held state.
    task automatic run_vec(input vec_t v, input string tag);
        int   L, c, budget;
        exp_t e;
        @(negedge clock); #1;
        L = 2 + (int'(v.term) + 1) * (int'(v.pre) + 1);
        c = cyc;
        en_cnt = 0;
        periodic = v.per;
        term_val = v.term;
        prescale = v.pre;
        start = 1'b1;
        for (int k = 1; k <= v.nper; k++) begin
            e.cyc = c + k * L;
            e.cnt = v.term;
            e.per = v.per ? PER_W'(k) : '0;
            sb.push_back(e);
        end
        @(negedge clock); #1;
        start = 1'b0;
        term_val = ~v.term;
        prescale = ~v.pre;
        periodic = ~v.per;
        chk({tag, "_clr_pulse"}, int'(cnt_clear), 1);
        chk({tag, "_busy_run"}, int'(busy), 1);
        budget = v.nper * L + 10;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clock); #1;
            budget--;
        end
        chk({tag, "_pending_dones"}, sb.size(), 0);
        sb.delete();
        stop = 1'b1;
        @(negedge clock); #1;
        stop = 1'b0;
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_enables"}, en_cnt, int'(v.term) * v.nper);
        chk({tag, "_periods"}, int'(periods), v.per ? v.nper : 0);
        repeat (3) @(negedge clock);
        #1;
        chk({tag, "_count_held"}, int'(count_in), int'(v.term));
        chk({tag, "_idle"}, int'(busy || cnt_enable || done), 0);
    endtask

    initial begin
        int budget;
        int held;
        vecs[0] = '{1'b0, 6'd5,  4'd0,  1};
        vecs[1] = '{1'b1, 6'd3,  4'd2,  3};
        vecs[2] = '{1'b0, 6'd0,  4'd3,  1};
        vecs[3] = '{1'b0, 6'd63, 4'd0,  1};
        vecs[4] = '{1'b1, 6'd2,  4'd1,  2};
        vecs[5] = '{1'b0, 6'd7,  4'd15, 1};

        // reset held for two edges
        @(negedge clock); clear = 1'b1;
        @(negedge clock);
        @(negedge clock); #1;
        clear = 1'b0;
        chk("rst_cnt_clear", int'(cnt_clear), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_enable", int'(cnt_enable), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_periods", int'(periods), 0);
        chk("rst_count", int'(count_in), 0);
        @(negedge clock); #1;
        chk("rst_clear_drop", int'(cnt_clear), 0);

        // start and stop together: stop wins
        held = int'(count_in);
        start = 1'b1; stop = 1'b1; term_val = 6'd5; prescale = 4'd0;
        @(negedge clock); #1;
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", int'(busy), 0);
        chk("ss_clear", int'(cnt_clear), 0);
        repeat (3) @(negedge clock);
        #1;
        chk("ss_still_idle", int'(busy || cnt_enable), 0);
        chk("ss_count", int'(count_in), held);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // stop mid-run at count 10 (prescale 1, so that cycle has no enable pending)
        @(negedge clock); #1;
        periodic = 1'b0; term_val = 6'd40; prescale = 4'd1; start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
        @(negedge clock); #1;
        budget = 200;
        while (count_in != 6'd10 && budget > 0) begin
            @(negedge clock); #1;
            budget--;
        end
        chk("stop_reach10", int'(count_in), 10);
        stop = 1'b1;
        @(negedge clock); #1;
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_enable", int'(cnt_enable), 0);
        chk("stop_count", int'(count_in), 10);
        repeat (4) @(negedge clock);
        #1;
        chk("stop_count_held", int'(count_in), 10);

        // clear mid-run at count 20
        periodic = 1'b0; term_val = 6'd40; prescale = 4'd0; start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
        budget = 100;
        while (count_in != 6'd20 && budget > 0) begin
            @(negedge clock); #1;
            budget--;
        end
        chk("clr_reach20", int'(count_in), 20);
        clear = 1'b1;
        @(negedge clock); #1;
        clear = 1'b0;
        chk("clr_cnt_clear", int'(cnt_clear), 1);
        chk("clr_busy", int'(busy), 0);
        chk("clr_enable", int'(cnt_enable), 0);
        chk("clr_done", int'(done), 0);
        chk("clr_periods", int'(periods), 0);
        @(negedge clock); #1;
        chk("clr_count_zero", int'(count_in), 0);
        chk("clr_pulse_end", int'(cnt_clear), 0);
        run_vec(vecs[0], "post_clear");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
